math_result_buffer: RTL and testbench
=====================================

# math_result_buffer

Downstream stage for the `math_equation` pipeline. The equation stage has no backpressure: its `valid_o`/`q` pair drives `valid_i`/`data_i` here one-for-one. This block buffers those results in a DEPTH-entry first-word-fall-through FIFO and re-presents them on a valid/ready interface. It counts results lost to overflow and tracks signed min/max statistics of every accepted result.

## Interface
- `WIDTH`, 16, operand width of the upstream equation stage; result width `RES_W = 2*WIDTH+2`.
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `valid_i`  in  1  upstream result strobe; no backpressure to upstream.
- `data_i`  in  RES_W  signed result from upstream.
- `clr_i`  in  1  clears statistics and overflow state; FIFO contents untouched.
- `valid_o`  out  1  head entry available (= not empty).
- `ready_i`  in  1  consumer accepts head this cycle.
- `data_o`  out  RES_W  head entry.
- `level_o`  out  $clog2(DEPTH)+1  current occupancy.
- `full_o` / `empty_o`  out  1  occupancy flags.
- `overflow_o`  out  1  sticky: at least one result dropped.
- `drop_cnt_o`  out  16  dropped-result count, saturating.
- `min_o` / `max_o`  out  RES_W  signed min/max of accepted results.
- `stats_valid_o`  out  1  min/max hold at least one sample.

## Operation
- Pop: `valid_o && ready_i`. Read pointer advances.
- Push: `valid_i && (!full_o || pop)`. Data is written at the write pointer, and the write pointer advances.
- Full with simultaneous pop: push is accepted, and level is unchanged.
- Empty: `ready_i` is ignored. No bypass from `data_i` to `data_o`.
- Drop: `valid_i && full_o && !pop`. Data is discarded, `overflow_o` is set, and `drop_cnt_o` increments, saturating at 16'hFFFF.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Level is tracked in a separate counter: +1 on push only, −1 on pop only, unchanged on both.
- Stats, on each accepted push:
  - If `!stats_valid_o`, then `min_o = max_o = data_i` and `stats_valid_o` is set.
  - Otherwise the signed compare updates `min_o`/`max_o`.
  - Equal values leave the registers unchanged.
- `clr_i`:
  - Zeros `overflow_o`, `drop_cnt_o`, `min_o`, `max_o` and `stats_valid_o`.
  - Same-cycle accepted push: that sample seeds the stats (`min = max = data_i`, `stats_valid = 1`).
  - Same-cycle drop: `overflow_o = 1` and `drop_cnt_o = 1`.
- All arithmetic on data is signed RES_W. No truncation or extension inside the block.

## Timing
- Reset values: `valid_o` 0, `empty_o` 1, `full_o` 0, `level_o` 0, `overflow_o` 0, `drop_cnt_o` 0, `min_o`/`max_o` 0, `stats_valid_o` 0, `data_o` 0.
- Reset asserted mid-operation flushes all pointers and state on that edge. Memory contents need no reset.
- Latency: a push at edge N gives `valid_o` = 1 and `data_o` = that value in the cycle after edge N. One cycle through an empty FIFO.
- `data_o` is a combinational read of the registered array at the read pointer. It is stable while `valid_o && !ready_i`.
- Flags, level, stats and drop outputs are all registered and update on the edge of the triggering event.
- Sustained throughput: one push plus one pop per cycle at any occupancy, including full.
- Upstream can strobe `valid_i` every cycle. No rate assumption is made.

## Structure
- Shared package `math_pkg` holds:
  - `RES_W` as a function of WIDTH;
  - typedef `result_t` (`logic signed [RES_W-1:0]`);
  - localparam `DROP_CNT_W = 16`.
- The upstream `math_equation` stage also adopts this package for its `q` width.
- One sub-module: `sync_fifo` (generic parameterized storage, pointers, level, full/empty). It is reused elsewhere.
- Drop counter, overflow and min/max logic stay in `math_result_buffer`.

## Test plan
- Reset, then single push of 34'sh0_0000_0005 with `ready_i`=1:
  - `valid_o` is high one cycle later with `data_o` = 5;
  - `level_o` returns to 0;
  - `min_o` = `max_o` = 5.
- Push 8 values 1..8 with `ready_i`=0 (DEPTH=8):
  - `full_o`=1 and `level_o`=8;
  - a ninth push (value 9) is dropped: `overflow_o`=1, `drop_cnt_o`=1;
  - draining yields 1..8 in order.
- Full FIFO with simultaneous push (value 9) and pop:
  - no drop; `level_o` stays 8;
  - the pop returns 1, and value 9 later emerges last.
- Signed stats: push −3, 7, −10, 2:
  - `min_o` = −10 and `max_o` = 7;
  - `clr_i` together with a push of 4 gives `min_o` = `max_o` = 4 and `stats_valid_o` = 1.
- Drop saturation: force 70000 drops; `drop_cnt_o` holds 16'hFFFF.
- Reset asserted with `level_o`=5: next cycle `empty_o`=1, `valid_o`=0, and all stats are 0.

Source files
------------

// File: rtl/math_pkg.sv
// Shared definitions for the math_equation pipeline and its result buffer.
// The result width is derived from the operand width so both stages agree on it.
package math_pkg;

  localparam int EQ_WIDTH = 16;

  function automatic int res_w(input int width);
    return 2 * width + 2;
  endfunction

  localparam int RES_W = res_w(EQ_WIDTH);

  typedef logic signed [RES_W-1:0] result_t;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO: registered storage, wrapping pointers,
// a separate occupancy counter and registered full/empty flags.
module sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_full;
  logic          r_empty;

  logic          w_pop;
  logic          w_push;
  logic [LW-1:0] w_level_nxt;

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign w_pop  = pop_i && !r_empty;
  assign w_push = push_i && (!r_full || w_pop);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) w_level_nxt = r_level + LW'(1);
    else if (w_pop && !w_push) w_level_nxt = r_level - LW'(1);
  end

  // NOTE: storage has no reset; contents are only observable once a push
  // has written them, and leaving it out keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  // Gate the head read so the output is a defined zero while empty.
  assign data_o  = r_empty ? '0 : r_mem[r_rd_ptr];
  assign level_o = r_level;
  assign full_o  = r_full;
  assign empty_o = r_empty;

endmodule

// File: rtl/math_result_buffer.sv
// Buffers math_equation results in a FWFT FIFO, re-presents them on valid/ready,
// counts overflow drops and tracks signed min/max of accepted results.
module math_result_buffer
  import math_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int DW    = res_w(WIDTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic signed [DW-1:0]  data_i,
  input  logic                  clr_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic signed [DW-1:0]  data_o,
  output logic [LW-1:0]         level_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
  output logic signed [DW-1:0]  min_o,
  output logic signed [DW-1:0]  max_o,
  output logic                  stats_valid_o
);

  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [DW-1:0]         w_fifo_q;

  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic signed [DW-1:0]  r_min;
  logic signed [DW-1:0]  r_max;
  logic                  r_stats_valid;

  assign w_pop  = !w_empty && ready_i;
  assign w_push = valid_i && (!w_full || w_pop);
  assign w_drop = valid_i && w_full && !w_pop;

  sync_fifo #(
    .W     (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (data_i),
    .data_o  (w_fifo_q),
    .level_o (level_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // A same-cycle clear wins over history but not over the event in that cycle:
  // a drop restarts the count at one, a push seeds fresh statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow    <= 1'b0;
      r_drop_cnt    <= '0;
      r_min         <= '0;
      r_max         <= '0;
      r_stats_valid <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (clr_i)                           r_drop_cnt <= DROP_CNT_W'(1);
        else if (r_drop_cnt != DROP_CNT_MAX) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end else if (clr_i) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end

      if (w_push) begin
        if (!r_stats_valid || clr_i) begin
          r_min         <= data_i;
          r_max         <= data_i;
          r_stats_valid <= 1'b1;
        end else begin
          if (data_i < r_min) r_min <= data_i;
          if (data_i > r_max) r_max <= data_i;
        end
      end else if (clr_i) begin
        r_min         <= '0;
        r_max         <= '0;
        r_stats_valid <= 1'b0;
      end
    end
  end

  assign valid_o       = !w_empty;
  assign empty_o       = w_empty;
  assign full_o        = w_full;
  assign data_o        = w_fifo_q;
  assign overflow_o    = r_overflow;
  assign drop_cnt_o    = r_drop_cnt;
  assign min_o         = r_min;
  assign max_o         = r_max;
  assign stats_valid_o = r_stats_valid;

endmodule

// File: tb/tb_math_result_buffer.sv
// Randomized and directed bench for math_result_buffer against a queue-based
// reference model of the buffer, drop counter and min/max statistics.
module tb_math_result_buffer;
  import math_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  valid_i;
  result_t               data_i;
  logic                  clr_i;
  logic                  valid_o;
  logic                  ready_i;
  result_t               data_o;
  logic [LW-1:0]         level_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  overflow_o;
  logic [DROP_CNT_W-1:0] drop_cnt_o;
  result_t               min_o;
  result_t               max_o;
  logic                  stats_valid_o;

  math_result_buffer #(.WIDTH(EQ_WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .clr_i         (clr_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .data_o        (data_o),
    .level_o       (level_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .overflow_o    (overflow_o),
    .drop_cnt_o    (drop_cnt_o),
    .min_o         (min_o),
    .max_o         (max_o),
    .stats_valid_o (stats_valid_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  result_t m_q[$];
  bit      m_ovf;
  int      m_drops;
  result_t m_min;
  result_t m_max;
  bit      m_sv;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("valid_o", 64'(valid_o), 64'(m_q.size() != 0));
    check("empty_o", 64'(empty_o), 64'(m_q.size() == 0));
    check("full_o", 64'(full_o), 64'(m_q.size() == DEPTH));
    check("level_o", 64'(level_o), 64'(m_q.size()));
    check("data_o", 64'(data_o), (m_q.size() != 0) ? 64'(m_q[0]) : 64'd0);
    check("overflow_o", 64'(overflow_o), 64'(m_ovf));
    check("drop_cnt_o", 64'(drop_cnt_o), 64'((m_drops > 65535) ? 65535 : m_drops));
    check("min_o", 64'(min_o), 64'(m_min));
    check("max_o", 64'(max_o), 64'(m_max));
    check("stats_valid_o", 64'(stats_valid_o), 64'(m_sv));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_drops = 0; m_min = '0; m_max = '0; m_sv = 0;
  endtask

  // One clock: drive inputs, advance the model by the buffer's rules, compare.
  task automatic step(input bit v, input result_t d, input bit r, input bit c);
    bit can_pop, is_full, acc, drp;
    valid_i = v; data_i = d; ready_i = r; clr_i = c;
    can_pop = (m_q.size() != 0) && r;
    is_full = (m_q.size() == DEPTH);
    acc     = v && (!is_full || can_pop);
    drp     = v && is_full && !can_pop;
    if (can_pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(d);
    if (c) begin m_ovf = 0; m_drops = 0; m_min = '0; m_max = '0; m_sv = 0; end
    if (drp) begin m_ovf = 1; m_drops = (m_drops >= 65535) ? 65535 : m_drops + 1; end
    if (acc) begin
      if (!m_sv) begin m_min = d; m_max = d; m_sv = 1; end
      else begin
        if (d < m_min) m_min = d;
        if (d > m_max) m_max = d;
      end
    end
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b0; clr_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    compare_all();
  endtask

  function automatic result_t rand_val();
    result_t v;
    if ($urandom_range(0, 2) == 0) v = result_t'($signed($urandom_range(0, 8)) - 4);
    else v = result_t'({$urandom, $urandom});
    return v;
  endfunction

  initial begin
    rst = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b0; clr_i = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Single push, one-cycle latency, then popped
    step(1, 34'sd5, 1, 0);
    check("first_valid", 64'(valid_o), 64'd1);
    check("first_data", 64'(data_o), 64'd5);
    step(0, '0, 1, 0);
    check("first_level_back", 64'(level_o), 64'd0);
    check("first_min", 64'(min_o), 64'd5);
    check("first_max", 64'(max_o), 64'd5);

    // Fill, drop, drain in order
    for (int i = 1; i <= 8; i++) step(1, result_t'(i), 0, 0);
    check("fill_full", 64'(full_o), 64'd1);
    check("fill_level", 64'(level_o), 64'd8);
    step(1, 34'sd9, 0, 0);
    check("drop_ovf", 64'(overflow_o), 64'd1);
    check("drop_cnt", 64'(drop_cnt_o), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", 64'(data_o), 64'(i));
      step(0, '0, 1, 0);
    end

    // Full with simultaneous push and pop
    for (int i = 1; i <= 8; i++) step(1, result_t'(i), 0, 0);
    check("pp_head", 64'(data_o), 64'd1);
    step(1, 34'sd9, 1, 0);
    check("pp_level", 64'(level_o), 64'd8);
    check("pp_no_drop", 64'(drop_cnt_o), 64'd1);
    for (int i = 2; i <= 9; i++) begin
      check("pp_order", 64'(data_o), 64'(i));
      step(0, '0, 1, 0);
    end

    // Signed statistics and clear with same-cycle push
    do_reset();
    step(1, -34'sd3, 1, 0);
    step(1, 34'sd7, 1, 0);
    step(1, -34'sd10, 1, 0);
    step(1, 34'sd2, 1, 0);
    check("stats_min", 64'(min_o), 64'(-34'sd10));
    check("stats_max", 64'(max_o), 64'(34'sd7));
    step(1, 34'sd4, 1, 1);
    check("clr_min", 64'(min_o), 64'd4);
    check("clr_max", 64'(max_o), 64'd4);
    check("clr_sv", 64'(stats_valid_o), 64'd1);
    step(0, '0, 1, 0);

    // Drop counter saturation
    for (int i = 0; i < DEPTH; i++) step(1, rand_val(), 0, 0);
    for (int i = 0; i < 70000; i++) step(1, rand_val(), 0, 0);
    check("drop_sat", 64'(drop_cnt_o), 64'hFFFF);
    step(1, '0, 0, 1);
    check("clr_drop_restart", 64'(drop_cnt_o), 64'd1);

    // Reset with level 5
    do_reset();
    for (int i = 0; i < 5; i++) step(1, rand_val(), 0, 0);
    check("pre_rst_level", 64'(level_o), 64'd5);
    do_reset();
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_stats", 64'({min_o, max_o, stats_valid_o}), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, rand_val(), $urandom_range(0, 2) != 0,
                $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
